// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: steps each instruction through fetch..commit and issues one-shot enables.
// Optional performance counters are built when SEQ_PERF_CNT_EN is defined.
module instr_sequencer #(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_branch,
  input  logic             ctrl_regwr,
  input  logic             mem_ready,
  output logic             ir_en,
  output logic             pc_en,
  output logic             reg_wr_en,
  output logic             mem_req,
  output logic             mem_wr_en,
  output logic [2:0]       phase,
  output logic             mem_err,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_COMMIT = 3'd6
  } state_t;

  localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);
  localparam logic       TMO_EN   = (MEM_WAIT_MAX != 0);

  state_t     r_state;
  logic       r_is_load;
  logic       r_is_store;
  logic [7:0] r_wait_cnt;
  logic       r_mem_err;

  logic w_in_fetch;
  logic w_in_mem;
  logic w_timeout;

  assign w_in_fetch = (r_state == S_FETCH);
  assign w_in_mem   = (r_state == S_MEM);
  assign w_timeout  = w_in_mem & TMO_EN & (r_wait_cnt == WAIT_MAX) & ~mem_ready;

  // Phase sequencing, op-class capture, MEM wait counting and the sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_wait_cnt <= 8'd0;
      r_mem_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  r_state <= hold ? S_FETCH : S_DECODE;
        S_DECODE: r_state <= S_EXEC;
        S_EXEC: begin
          // A simultaneous load/store decode is treated as a load.
          r_is_load  <= is_load;
          r_is_store <= is_store & ~is_load;
          r_wait_cnt <= 8'd0;
          if (is_load | is_store) begin
            r_state <= S_MEM;
          end else if (is_branch) begin
            r_state <= S_COMMIT;
          end else begin
            r_state <= S_WB;
          end
        end
        S_MEM: begin
          if (w_timeout) begin
            r_mem_err <= 1'b1;
            r_state   <= S_COMMIT;
          end else if (mem_ready) begin
            r_state <= r_is_load ? S_WB : S_COMMIT;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_WB:     r_state <= S_COMMIT;
        S_COMMIT: r_state <= S_FETCH;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Enables react to hold/mem_ready within the cycle and are killed while rst is high.
  assign ir_en     = ~rst & w_in_fetch & ~hold;
  assign pc_en     = ~rst & (r_state == S_COMMIT);
  assign reg_wr_en = ~rst & (r_state == S_WB) & ctrl_regwr;
  assign mem_req   = ~rst & w_in_mem;
  assign mem_wr_en = ~rst & w_in_mem & r_is_store & mem_ready & ~w_timeout;
  assign phase     = r_state;
  assign mem_err   = r_mem_err;

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] r_retire_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Retired-instruction and stall-cycle counters, wrapping modulo 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retire_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (pc_en) begin
        r_retire_cnt <= r_retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if ((w_in_fetch & hold) | (w_in_mem & ~mem_ready)) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign retire_cnt = r_retire_cnt;
  assign stall_cnt  = r_stall_cnt;
`else
  assign retire_cnt = '0;
  assign stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: per-cycle phase/enable vectors plus counter and mem_err checks.
module tb_instr_sequencer;

  logic        clk = 1'b0;
  logic        rst, hold, is_load, is_store, is_branch, ctrl_regwr, mem_ready;
  logic        ir_en, pc_en, reg_wr_en, mem_req, mem_wr_en, mem_err;
  logic [2:0]  phase;
  logic [31:0] retire_cnt, stall_cnt;

  int errs   = 0;
  int checks = 0;

`ifdef SEQ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // Enable bit positions within the {ir,pc,rw,req,wr} field
  localparam logic [4:0] IR = 5'b10000;
  localparam logic [4:0] PC = 5'b01000;
  localparam logic [4:0] RW = 5'b00100;
  localparam logic [4:0] RQ = 5'b00010;
  localparam logic [4:0] WR = 5'b00001;
  localparam logic [4:0] NO = 5'b00000;

  always #5 clk = ~clk;

  instr_sequencer #(.MEM_WAIT_MAX(3), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .hold(hold), .is_load(is_load), .is_store(is_store),
    .is_branch(is_branch), .ctrl_regwr(ctrl_regwr), .mem_ready(mem_ready),
    .ir_en(ir_en), .pc_en(pc_en), .reg_wr_en(reg_wr_en), .mem_req(mem_req),
    .mem_wr_en(mem_wr_en), .phase(phase), .mem_err(mem_err),
    .retire_cnt(retire_cnt), .stall_cnt(stall_cnt)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ex(input logic [2:0] ph, input logic [4:0] en);
    return {ph, en};
  endfunction

  // in_v = {rst, hold, is_load, is_store, is_branch, ctrl_regwr, mem_ready}
  task automatic cyc(input string tag, input logic [6:0] in_v, input logic [7:0] exp_v);
    @(negedge clk);
    {rst, hold, is_load, is_store, is_branch, ctrl_regwr, mem_ready} = in_v;
    #1;
    check(tag, {56'd0, phase, ir_en, pc_en, reg_wr_en, mem_req, mem_wr_en}, {56'd0, exp_v});
  endtask

  task automatic cnts(input string tag, input int ret, input int stl);
    check({tag, "_ret"}, {32'd0, retire_cnt}, PERF ? 64'(ret) : 64'd0);
    check({tag, "_stl"}, {32'd0, stall_cnt},  PERF ? 64'(stl) : 64'd0);
  endtask

  initial begin
    {rst, hold, is_load, is_store, is_branch, ctrl_regwr, mem_ready} = 7'b1000000;
    cyc("rst0", 7'b1000000, ex(3'd0, NO));
    cyc("rst1", 7'b1000000, ex(3'd0, NO));
    check("rst_err", {63'd0, mem_err}, 64'd0);
    cnts("rst", 0, 0);
    cyc("idle", 7'b0000000, ex(3'd0, NO));

    // Three ALU instructions, RegWr=1, no stalls
    for (int n = 0; n < 3; n++) begin
      cyc("alu_f", 7'b0000010, ex(3'd1, IR));
      cyc("alu_d", 7'b0000010, ex(3'd2, NO));
      cyc("alu_e", 7'b0000010, ex(3'd3, NO));
      cyc("alu_w", 7'b0000010, ex(3'd5, RW));
      cyc("alu_c", 7'b0000010, ex(3'd6, PC));
    end

    // Store: ready high (ignored) outside MEM, low 3 MEM cycles, then high at the wait limit
    cyc("st_f", 7'b0001011, ex(3'd1, IR));
    cnts("alu3", 3, 0);
    cyc("st_d", 7'b0001011, ex(3'd2, NO));
    cyc("st_e", 7'b0001011, ex(3'd3, NO));
    for (int n = 0; n < 3; n++) cyc("st_mwait", 7'b0001010, ex(3'd4, RQ));
    cyc("st_mwr", 7'b0001011, ex(3'd4, RQ | WR));
    cyc("st_c", 7'b0001010, ex(3'd6, PC));
    check("st_err", {63'd0, mem_err}, 64'd0);

    // Load with mem_ready stuck low: times out after MEM_WAIT_MAX+1 = 4 MEM cycles
    cyc("ldt_f", 7'b0010010, ex(3'd1, IR));
    cnts("st", 4, 3);
    cyc("ldt_d", 7'b0010010, ex(3'd2, NO));
    cyc("ldt_e", 7'b0010010, ex(3'd3, NO));
    for (int n = 0; n < 4; n++) cyc("ldt_m", 7'b0010010, ex(3'd4, RQ));
    cyc("ldt_c", 7'b0010010, ex(3'd6, PC));
    check("ldt_err", {63'd0, mem_err}, 64'd1);

    // Load and store both decoded: treated as load, WB follows MEM, no write
    cyc("ld_f", 7'b0011011, ex(3'd1, IR));
    cnts("ldt", 5, 7);
    cyc("ld_d", 7'b0011011, ex(3'd2, NO));
    cyc("ld_e", 7'b0011011, ex(3'd3, NO));
    cyc("ld_m", 7'b0011011, ex(3'd4, RQ));
    cyc("ld_w", 7'b0011011, ex(3'd5, RW));
    cyc("ld_c", 7'b0011011, ex(3'd6, PC));

    // Branch: 4 cycles, no MEM/WB
    cyc("br_f", 7'b0000110, ex(3'd1, IR));
    cyc("br_d", 7'b0000110, ex(3'd2, NO));
    cyc("br_e", 7'b0000110, ex(3'd3, NO));
    cyc("br_c", 7'b0000110, ex(3'd6, PC));

    // Hold for 6 FETCH cycles, then released; hold outside FETCH has no effect; RegWr=0
    for (int n = 0; n < 6; n++) cyc("hold_f", 7'b0100000, ex(3'd1, NO));
    cyc("hold_rel", 7'b0000000, ex(3'd1, IR));
    cyc("hold_d", 7'b0100000, ex(3'd2, NO));
    cyc("hold_e", 7'b0100000, ex(3'd3, NO));
    cyc("hold_w", 7'b0100000, ex(3'd5, NO));
    cyc("hold_c", 7'b0100000, ex(3'd6, PC));
    check("hold_err", {63'd0, mem_err}, 64'd1);

    // Store interrupted by rst in MEM with ready high
    cyc("rs_f", 7'b0001011, ex(3'd1, IR));
    cnts("hold", 8, 13);
    cyc("rs_d", 7'b0001011, ex(3'd2, NO));
    cyc("rs_e", 7'b0001011, ex(3'd3, NO));
    cyc("rs_mrst", 7'b1001011, ex(3'd4, NO));
    cyc("rs_idle", 7'b0000000, ex(3'd0, NO));
    check("rs_err", {63'd0, mem_err}, 64'd0);
    cnts("rs", 0, 0);
    cyc("rs_f2", 7'b0000000, ex(3'd1, IR));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
